// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle word-addressed data memory behind a req/ack handshake
// Ports:
//    clk_i    rising-edge clock
//    rst_i    asynchronous active-high reset
//    req_i    request valid, held with stable we/addr/wdata until ack_o
//    we_i     1 = store, 0 = load
//    addr_i   byte address
//    wdata_i  store data
//    ack_o    one-cycle completion pulse
//    rdata_o  load data, valid with ack_o and held afterwards
//    busy_o   high while a transaction is outstanding (WAIT or ACK)
//    err_o    misaligned/out-of-range flag, qualified by ack_o
module data_memory_responder #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o,
   output logic              err_o
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [31:0]       addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   logic              legal;
   logic              commit;
   logic [AW-1:0]     idx;
   always_comb begin
      legal  = addr_q[1:0] == 2'b00 && {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
      idx    = addr_q[AW+1:2];
      commit = state == WAIT && cnt == 4'd0;
   end
   // Array has no reset; reset forces IDLE, so an aborted access never reaches commit.
   always_ff @(posedge clk_i)
      if (commit && legal && we_q) mem[idx] <= wdata_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ack_o   <= 1'b0;
         busy_o  <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         ack_o <= 1'b0;
         case (state)
            IDLE: if (req_i) begin
               addr_q  <= addr_i;
               we_q    <= we_i;
               wdata_q <= wdata_i;
               cnt     <= 4'(LATENCY - 1);
               state   <= WAIT;
               busy_o  <= 1'b1;
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               state <= ACK;
               ack_o <= 1'b1;
               err_o <= !legal;
               if (legal && !we_q) rdata_o <= mem[idx];
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of data_memory_responder at LATENCY 4 and 1
module tb_data_memory_responder;
   logic        clk = 0;
   logic        rst = 1;
   logic        req = 0;
   logic        we = 0;
   logic        use1 = 0;
   logic [31:0] addr = 0;
   logic [31:0] wdata = 0;
   logic        ack0, busy0, err0, ack1, busy1, err1;
   logic [31:0] rdata0, rdata1;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat, bc;
   logic [31:0] rd;
   logic        er;

   always #5 clk = ~clk;

   data_memory_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .req_i(req & ~use1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0), .err_o(err0));

   data_memory_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req & use1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1));

   // Drives one transaction on the selected instance; lat is cycles from capture edge to ack (-1 on timeout).
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int l, output int b, output logic [31:0] r, output logic e);
      l = -1; b = 0; r = 'x; e = 'x;
      @(posedge clk); #1;
      req = 1; we = w; addr = a; wdata = d;
      for (int c = 1; c <= 20 && l < 0; c++) begin
         @(posedge clk); #1;
         if (use1 ? busy1 : busy0) b++;
         if (use1 ? ack1 : ack0) begin
            l = c - 1;
            r = use1 ? rdata1 : rdata0;
            e = use1 ? err1 : err0;
            req = 0;
         end
      end
      req = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      vectors++; if ({ack0, busy0, err0} !== 3'b000) begin miscompares++; $display("FAIL reset_flags4 got %b exp 000", {ack0, busy0, err0}); end
      vectors++; if (rdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata4 got %h exp 00000000", rdata0); end
      vectors++; if ({ack1, busy1, err1, rdata1} !== 35'h0) begin miscompares++; $display("FAIL reset_dut1 got %h exp 0", {ack1, busy1, err1, rdata1}); end
   endtask

   task automatic test_store;
      run_txn(1, 32'h10, 32'hDEADBEEF, lat, bc, rd, er);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL store_latency got %0d exp 4", lat); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL store_err got %b exp 0", er); end
      @(posedge clk); #1;
      vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("FAIL ack_one_cycle got %b exp 0", ack0); end
      vectors++; if (bc !== 5 || busy0 !== 1'b0) begin miscompares++; $display("FAIL busy_cycles got %0d/%b exp 5/0", bc, busy0); end
   endtask

   task automatic test_load_back;
      run_txn(0, 32'h10, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("FAIL load_back got %h/%b exp deadbeef/0", rd, er); end
      repeat (3) @(posedge clk); #1;
      vectors++; if (rdata0 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rdata_hold got %h exp deadbeef", rdata0); end
   endtask

   task automatic test_errors;
      run_txn(0, 32'h12, 32'h0, lat, bc, rd, er);
      vectors++; if (lat !== 4 || er !== 1'b1) begin miscompares++; $display("FAIL misaligned_err got %0d/%b exp 4/1", lat, er); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL misaligned_rdata got %h exp deadbeef", rd); end
      run_txn(1, 32'h0, 32'h01234567, lat, bc, rd, er);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL store_word0_err got %b exp 0", er); end
      run_txn(1, 32'h1000, 32'h00000BAD, lat, bc, rd, er);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL range_err got %b exp 1", er); end
      run_txn(0, 32'h0, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'h01234567 || er !== 1'b0) begin miscompares++; $display("FAIL word0_intact got %h/%b exp 01234567/0", rd, er); end
      run_txn(1, 32'hFFC, 32'hFFC0FFC0, lat, bc, rd, er);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL top_store_err got %b exp 0", er); end
      run_txn(0, 32'hFFC, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'hFFC0FFC0 || er !== 1'b0) begin miscompares++; $display("FAIL top_load got %h/%b exp ffc0ffc0/0", rd, er); end
   endtask

   task automatic test_back_to_back;
      int acks, first, second;
      acks = 0; first = -1; second = -1;
      @(posedge clk); #1;
      req = 1; we = 1; addr = 32'h4; wdata = 32'h44440004;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (ack0) begin
            acks++;
            if (acks == 1) begin
               first = c; addr = 32'h8; wdata = 32'h88880008;
            end else begin
               if (acks == 2) second = c;
               req = 0;
            end
         end
      end
      req = 0;
      vectors++; if (acks !== 2) begin miscompares++; $display("FAIL b2b_count got %0d exp 2", acks); end
      vectors++; if (second - first !== 6) begin miscompares++; $display("FAIL b2b_spacing got %0d exp 6", second - first); end
      run_txn(0, 32'h4, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'h44440004) begin miscompares++; $display("FAIL b2b_word1 got %h exp 44440004", rd); end
      run_txn(0, 32'h8, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'h88880008) begin miscompares++; $display("FAIL b2b_word2 got %h exp 88880008", rd); end
   endtask

   task automatic test_reset_abort;
      int acks;
      acks = 0;
      run_txn(1, 32'h20, 32'hAA, lat, bc, rd, er);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL pre_store_err got %b exp 0", er); end
      @(posedge clk); #1;
      req = 1; we = 1; addr = 32'h20; wdata = 32'h55;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before got %b exp 1", busy0); end
      rst = 1; req = 0;
      #1;
      vectors++; if (busy0 !== 1'b0 || ack0 !== 1'b0) begin miscompares++; $display("FAIL abort_async got busy=%b ack=%b exp 0/0", busy0, ack0); end
      @(posedge clk); #1 rst = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (ack0) acks++;
      end
      vectors++; if (acks !== 0) begin miscompares++; $display("FAIL abort_no_ack got %0d exp 0", acks); end
      run_txn(0, 32'h20, 32'h0, lat, bc, rd, er);
      vectors++; if (rd !== 32'hAA) begin miscompares++; $display("FAIL abort_no_write got %h exp 000000aa", rd); end
   endtask

   task automatic test_latency1;
      use1 = 1;
      run_txn(1, 32'h0, 32'hCAFEF00D, lat, bc, rd, er);
      vectors++; if (lat !== 1 || bc !== 2) begin miscompares++; $display("FAIL lat1_store got %0d/%0d exp 1/2", lat, bc); end
      run_txn(1, 32'h4, 32'h12345678, lat, bc, rd, er);
      @(posedge clk); #1;
      req = 1; we = 0; addr = 32'h0;
      @(posedge clk); #1;
      addr = 32'h4;
      vectors++; if (ack1 !== 1'b0 || busy1 !== 1'b1) begin miscompares++; $display("FAIL lat1_wait got ack=%b busy=%b exp 0/1", ack1, busy1); end
      @(posedge clk); #1;
      vectors++; if (ack1 !== 1'b1 || rdata1 !== 32'hCAFEF00D || err1 !== 1'b0) begin miscompares++; $display("FAIL lat1_load got ack=%b rdata=%h err=%b exp 1/cafef00d/0", ack1, rdata1, err1); end
      req = 0;
      @(posedge clk); #1;
      vectors++; if (ack1 !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL lat1_done got ack=%b busy=%b exp 0/0", ack1, busy1); end
      use1 = 0;
   endtask

   initial begin
      test_reset;
      test_store;
      test_load_back;
      test_errors;
      test_back_to_back;
      test_reset_abort;
      test_latency1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Multi-cycle data-memory target serving load/store requests from the CPU MEM stage over a req/ack handshake.
- Models off-core memory with a fixed, parameterised access latency.
- busy_o is driven to the hazard logic so the pipeline stalls while an access is outstanding.
- Holds the word-addressed storage array and flags misaligned or out-of-range accesses.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH_WORDS, 1024, number of words in the array; must be a power of 2.
- LATENCY, 4, cycles from the request-capture edge to the ack cycle; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  request valid; requester holds it, with stable addr/we/wdata, until it sees ack_o.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- wdata_i  input  DATA_W  store data.
- ack_o  input/output: output  1  one-cycle completion pulse.
- rdata_o  output  DATA_W  load data, valid while ack_o=1 and held afterwards.
- busy_o  output  1  high while a transaction is in progress (WAIT or ACK state).
- err_o  output  1  error flag, qualified by ack_o.

Behaviour:
- States: IDLE, WAIT, ACK.
- Latency counter cnt is 4 bits.
- Request latches: addr_q, we_q, wdata_q.

Reset (rst_i=1, asynchronous):
- State goes to IDLE; cnt=0.
- ack_o=0, busy_o=0, err_o=0, rdata_o=0.
- The storage array is not cleared.
- Reset in any state aborts the transaction. No write occurs unless the commit edge has already passed.

IDLE:
- If req_i=1 at a rising edge: latch addr_i, we_i and wdata_i; set cnt=LATENCY-1; go to WAIT.
- Otherwise stay in IDLE.

WAIT:
- If cnt!=0, decrement cnt.
- If cnt==0, this is the commit edge. Go to ACK and perform the access on this edge using the latched values:
  - Legal access (addr_q[1:0]==0 and addr_q[31:2] < DEPTH_WORDS):
    - Store: mem[addr_q[31:2]] <= wdata_q; rdata_o unchanged.
    - Load: rdata_o <= mem[addr_q[31:2]].
    - err_o <= 0.
  - Illegal access: no array write, rdata_o unchanged, err_o <= 1.
- req_i, addr_i, we_i and wdata_i are ignored in WAIT; only the latched copies are used.

ACK:
- ack_o=1 for exactly this one cycle.
- Unconditionally return to IDLE at the next edge; req_i is ignored in ACK.

Outputs:
- ack_o and busy_o are registered.
- err_o holds its value until the next commit edge.
- busy_o=1 in WAIT and ACK.

Timing:
- Capture at edge T0; ack_o is high in the cycle after edge T0+LATENCY.
- Continuous requesting gives one transaction per LATENCY+2 cycles.
- The requester deasserts req_i at the edge after it samples ack_o=1, so no duplicate transaction is captured.

Boundary conditions:
- Load-after-store to the same word returns the new data.
- addr_i changing during WAIT has no effect.
- LATENCY=1 gives WAIT for one cycle only.
- Highest legal word address = DEPTH_WORDS-1; byte address 4*DEPTH_WORDS is out of range.

Test Plan:
1. Reset, then store: rst_i pulse; store addr=0x10, wdata=0xDEADBEEF, LATENCY=4.
   - ack_o rises 4 cycles after the capture edge and is high exactly 1 cycle.
   - busy_o is high for 5 cycles; err_o=0.
2. Load back: load addr=0x10 after test 1.
   - rdata_o=0xDEADBEEF while ack_o=1; value still held 3 cycles later.
3. Misaligned load: load addr=0x12 with rdata_o previously 0xDEADBEEF.
   - ack_o=1, err_o=1, rdata_o stays 0xDEADBEEF.
   - Out-of-range store to addr=0x1000 (DEPTH_WORDS=1024): err_o=1; a load of word 0 shows it unchanged.
4. Continuous requesting: req_i held high through ack for two stores, 0x4 then 0x8.
   - Exactly two transactions; ack pulses spaced LATENCY+2 = 6 cycles apart.
   - No third capture after req_i drops.
5. Reset mid-operation: store 0x55 to addr=0x20 (prior contents 0xAA); assert rst_i 2 cycles after capture.
   - ack_o never pulses; busy_o drops asynchronously.
   - A subsequent load of 0x20 returns 0xAA.
6. LATENCY=1 instance: load addr=0x0.
   - ack_o high in the second cycle after the capture edge.
   - addr_i toggled to 0x4 during WAIT has no effect: the returned data is mem[0].
